// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: turns a resolved taken branch or an exception into a
// valid/ready redirect to fetch, flushes IF/ID and ID/EX until the new path is clean.
module branch_redirect_ctrl #(
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exmem_valid,
  input  logic             exmem_branch,
  input  logic             branch_state,
  input  logic [31:0]      final_target,
  input  logic             exc_req,
  input  logic [31:0]      exc_vector,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_front,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // state | meaning
  // IDLE  | on the correct path, watching EX/MEM for redirects
  // REDIR | redirect_pc offered to fetch, waiting for redirect_ready
  // DRAIN | redirect accepted, flushing while fetch latency elapses
  typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state;
  logic [DW-1:0]   drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_front    <= 1'b0;
      busy           <= 1'b0;
      branch_cnt     <= '0;
      taken_cnt      <= '0;
      drain_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exmem_valid && exmem_branch) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (branch_state && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
          end
          // exception takes priority over a taken branch in the same cycle
          if (exc_req || (exmem_valid && branch_state)) begin
            redirect_pc    <= exc_req ? exc_vector : final_target;
            state          <= REDIR;
            redirect_valid <= 1'b1;
            flush_front    <= 1'b1;
            busy           <= 1'b1;
          end
        end
        REDIR: begin
          if (exc_req) begin
            redirect_pc <= exc_vector;
          end else if (redirect_ready) begin
            state          <= DRAIN;
            redirect_valid <= 1'b0;
            drain_cnt      <= DW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (exc_req) begin
            redirect_pc    <= exc_vector;
            redirect_valid <= 1'b1;
            state          <= REDIR;
          end else if (drain_cnt == '0) begin
            state       <= IDLE;
            flush_front <= 1'b0;
            busy        <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush_front    <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
